reg_scoreboard: RTL and testbench

//  Tracks pending writes to the 32x32 register file and gates instruction issue
//  so that no source is read and no destination is overrun while a write is in flight.

---
 rtl/reg_scoreboard_if.sv | 36 +++
 rtl/reg_scoreboard.sv | 119 +++++++++++
 tb/tb_reg_scoreboard.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/drain bundle between decode, the register-file write port and the scoreboard.
// The master side drives requests; the slave side (scoreboard) returns ready, masks and status.
interface reg_scoreboard_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int PW   = 16
);
    logic            issue_valid;
    logic [AW-1:0]   issue_rs;
    logic [AW-1:0]   issue_rt;
    logic            use_rs;
    logic            use_rt;
    logic            issue_wr;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic            flush;
    logic            drain_req;
    logic            drain_done;
    logic [NREG-1:0] busy_mask;
    logic            wb_error;
    logic [PW-1:0]   stall_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rt, use_rs, use_rt, issue_wr, issue_rd,
        output wb_valid, wb_rd, flush, drain_req,
        input  issue_ready, drain_done, busy_mask, wb_error, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rt, use_rs, use_rt, issue_wr, issue_rd,
        input  wb_valid, wb_rd, flush, drain_req,
        output issue_ready, drain_done, busy_mask, wb_error, stall_cnt
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Purpose: per-register pending-write counters gating issue, plus a drain/quiesce sequence.
// Latency: issue_ready is combinational (same-cycle writeback releases); drain_done >= 2 cycles after drain_req.
// Backpressure: issue_ready drops on RAW/WAW-overflow hazards, during flush, and outside RUN.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 2,
    parameter int PW   = 16
) (
    input  logic            clock,
    input  logic            reset,
    reg_scoreboard_if.slave sb
);
    localparam logic [1:0]    ST_RUN   = 2'd0;
    localparam logic [1:0]    ST_DRAIN = 2'd1;
    localparam logic [1:0]    ST_DONE  = 2'd2;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [PW-1:0] STALL_MAX = {PW{1'b1}};

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [1:0]      state_q, state_d;
    logic            wb_error_q, wb_error_d;
    logic [PW-1:0]   stall_cnt_q, stall_cnt_d;

    logic [NREG-1:0] wb_hit;
    logic [NREG-1:0] busy;
    logic [CW-1:0]   eff_rs, eff_rt, eff_rd;
    logic            ready;
    logic            fire;
    logic            inc;
    logic            all_zero_d;

    // A writeback landing this cycle is visible to readers, so hazards use the post-writeback count.
    always_comb begin
        wb_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            wb_hit[r] = sb.wb_valid && (sb.wb_rd == AW'(r)) && (cnt_q[r] != '0);
        end
        eff_rs = cnt_q[sb.issue_rs] - CW'(wb_hit[sb.issue_rs]);
        eff_rt = cnt_q[sb.issue_rt] - CW'(wb_hit[sb.issue_rt]);
        eff_rd = cnt_q[sb.issue_rd] - CW'(wb_hit[sb.issue_rd]);

        ready = (state_q == ST_RUN) && !sb.flush
              && !(sb.use_rs   && (sb.issue_rs != '0) && (eff_rs != '0))
              && !(sb.use_rt   && (sb.issue_rt != '0) && (eff_rt != '0))
              && !(sb.issue_wr && (sb.issue_rd != '0) && (eff_rd == CNT_MAX));
        fire = sb.issue_valid && ready;
    end

    always_comb begin
        inc        = 1'b0;
        all_zero_d = 1'b1;
        cnt_d[0]   = '0;
        for (int r = 1; r < NREG; r++) begin
            inc = fire && sb.issue_wr && (sb.issue_rd == AW'(r));
            if (sb.flush) begin
                cnt_d[r] = '0;
            end else begin
                cnt_d[r] = cnt_q[r] + CW'(inc) - CW'(wb_hit[r]);
            end
            if (cnt_d[r] != '0) begin
                all_zero_d = 1'b0;
            end
        end
    end

    always_comb begin
        wb_error_d = wb_error_q
                   | (sb.wb_valid && (sb.wb_rd != '0) && (cnt_q[sb.wb_rd] == '0) && !sb.flush);

        stall_cnt_d = stall_cnt_q;
        if (sb.issue_valid && !ready && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + PW'(1);
        end

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (sb.drain_req) state_d = ST_DRAIN;
            ST_DRAIN: if (all_zero_d)   state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        if (sb.flush) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            state_q     <= ST_RUN;
            wb_error_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            state_q     <= state_d;
            wb_error_q  <= wb_error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign sb.issue_ready = ready;
    assign sb.drain_done  = (state_q == ST_DONE);
    assign sb.busy_mask   = busy;
    assign sb.wb_error    = wb_error_q;
    assign sb.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, same-cycle release, r0, wb_error, flush, drain, async reset.
module tb_reg_scoreboard;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int PW   = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reg_scoreboard_if #(.NREG(NREG), .AW(AW), .PW(PW)) sb_if ();

    reg_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW), .PW(PW)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb_if)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb_if.issue_valid = 1'b0;
        sb_if.issue_rs    = '0;
        sb_if.issue_rt    = '0;
        sb_if.use_rs      = 1'b0;
        sb_if.use_rt      = 1'b0;
        sb_if.issue_wr    = 1'b0;
        sb_if.issue_rd    = '0;
        sb_if.wb_valid    = 1'b0;
        sb_if.wb_rd       = '0;
        sb_if.flush       = 1'b0;
        sb_if.drain_req   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_write(input logic [AW-1:0] rd);
        idle();
        sb_if.issue_valid = 1'b1;
        sb_if.issue_wr    = 1'b1;
        sb_if.issue_rd    = rd;
    endtask

    task automatic writeback(input logic [AW-1:0] rd);
        idle();
        sb_if.wb_valid = 1'b1;
        sb_if.wb_rd    = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        #12 reset = 1'b0;
        #1;
        chk("rst_busy",   sb_if.busy_mask,   32'h0);
        chk("rst_err",    sb_if.wb_error,    1'b0);
        chk("rst_stall",  sb_if.stall_cnt,   16'd0);
        chk("rst_done",   sb_if.drain_done,  1'b0);
        chk("rst_ready",  sb_if.issue_ready, 1'b1);

        // 1: RAW stall on r5, released by a same-cycle writeback
        tick();
        issue_write(5'd5); #1;
        chk("t1_wr5_ready", sb_if.issue_ready, 1'b1);
        tick();
        idle();
        sb_if.issue_valid = 1'b1; sb_if.use_rs = 1'b1; sb_if.issue_rs = 5'd5; #1;
        chk("t1_busy",      sb_if.busy_mask,   32'h0000_0020);
        chk("t1_raw_stall", sb_if.issue_ready, 1'b0);
        tick();
        chk("t1_stall_cnt", sb_if.stall_cnt,   16'd1);
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd5; #1;
        chk("t1_wb_release", sb_if.issue_ready, 1'b1);
        tick();
        chk("t1_busy_clr",  sb_if.busy_mask,   32'h0);
        chk("t1_stall_hold", sb_if.stall_cnt,  16'd1);

        // 2: three outstanding writes to r7 saturate; a same-cycle wb lets a 4th through
        issue_write(5'd7); #1;
        chk("t2_first_ready", sb_if.issue_ready, 1'b1);
        tick(); tick(); tick();
        chk("t2_busy7",     sb_if.busy_mask,   32'h0000_0080);
        chk("t2_sat_stall", sb_if.issue_ready, 1'b0);
        sb_if.wb_valid = 1'b1; sb_if.wb_rd = 5'd7; #1;
        chk("t2_sat_release", sb_if.issue_ready, 1'b1);
        tick();
        sb_if.wb_valid = 1'b0; #1;
        chk("t2_still_full", sb_if.issue_ready, 1'b0);
        tick();
        chk("t2_stall_cnt", sb_if.stall_cnt,   16'd2);
        writeback(5'd7);
        tick(); tick(); tick();
        idle(); #1;
        chk("t2_busy_clr",  sb_if.busy_mask,   32'h0);
        chk("t2_no_err",    sb_if.wb_error,    1'b0);

        // 3: r0 is never tracked
        issue_write(5'd0); #1;
        chk("t3_wr0_ready", sb_if.issue_ready, 1'b1);
        tick();
        idle();
        sb_if.issue_valid = 1'b1;
        sb_if.use_rs = 1'b1; sb_if.issue_rs = 5'd0;
        sb_if.use_rt = 1'b1; sb_if.issue_rt = 5'd0; #1;
        chk("t3_busy0",     sb_if.busy_mask,   32'h0);
        chk("t3_rd0_ready", sb_if.issue_ready, 1'b1);
        tick();
        writeback(5'd0);
        tick();
        chk("t3_wb0_no_err", sb_if.wb_error,   1'b0);
        chk("t3_stall_cnt", sb_if.stall_cnt,   16'd2);

        // 4: stray writeback sets sticky error; flush clears counters but not the error
        issue_write(5'd12);
        tick();
        writeback(5'd9); #1;
        chk("t4_busy12",    sb_if.busy_mask,   32'h0000_1000);
        chk("t4_err_pre",   sb_if.wb_error,    1'b0);
        tick();
        chk("t4_err_set",   sb_if.wb_error,    1'b1);
        idle(); sb_if.flush = 1'b1; #1;
        chk("t4_flush_ready", sb_if.issue_ready, 1'b0);
        tick();
        idle(); #1;
        chk("t4_flush_busy", sb_if.busy_mask,  32'h0);
        chk("t4_err_sticky", sb_if.wb_error,   1'b1);
        tick();
        chk("t4_err_sticky2", sb_if.wb_error,  1'b1);

        // 5: drain with r3/r4 pending
        issue_write(5'd3);
        tick();
        issue_write(5'd4);
        tick();
        idle(); sb_if.drain_req = 1'b1; #1;
        chk("t5_busy34",    sb_if.busy_mask,   32'h0000_0018);
        chk("t5_run_ready", sb_if.issue_ready, 1'b1);
        tick();
        idle(); #1;
        chk("t5_drain_ready", sb_if.issue_ready, 1'b0);
        writeback(5'd3);
        tick();
        chk("t5_busy4",     sb_if.busy_mask,   32'h0000_0010);
        chk("t5_no_done",   sb_if.drain_done,  1'b0);
        writeback(5'd4);
        tick();
        idle(); #1;
        chk("t5_done",      sb_if.drain_done,  1'b1);
        chk("t5_done_ready", sb_if.issue_ready, 1'b0);
        chk("t5_busy_clr",  sb_if.busy_mask,   32'h0);
        tick();
        chk("t5_done_pulse", sb_if.drain_done, 1'b0);
        chk("t5_run_again", sb_if.issue_ready, 1'b1);

        // 6: async reset mid-DRAIN
        issue_write(5'd6);
        tick();
        idle(); sb_if.drain_req = 1'b1;
        tick();
        idle();
        tick();
        chk("t6_busy6",     sb_if.busy_mask,   32'h0000_0040);
        chk("t6_draining",  sb_if.issue_ready, 1'b0);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_busy",  sb_if.busy_mask,   32'h0);
        chk("t6_rst_err",   sb_if.wb_error,    1'b0);
        chk("t6_rst_stall", sb_if.stall_cnt,   16'd0);
        chk("t6_rst_ready", sb_if.issue_ready, 1'b1);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_done", sb_if.drain_done, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
